u2_addsub_seq: RTL
==================

Name: u2_addsub_seq

Overview:
Parametrised multi-cycle two's-complement (U2) adder/subtractor. It processes operands CHUNK bits per clock, LSB chunk first, with a ripple carry held in a register between chunks. Operands enter and results leave through valid/ready handshakes. It is the sequential, width-generic successor to the 4-bit U2 ripple adder, and adds subtract mode, status flags and optional saturation.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CHUNK, 2, bits processed per cycle; WIDTH % CHUNK must be 0 and CHUNK >= 1, otherwise elaboration error
(derived) N = WIDTH/CHUNK, number of RUN cycles; width of chunk counter = clog2(N), minimum 1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A, signed U2
b  input  WIDTH  operand B, signed U2
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: add, 1: subtract
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  raw carry out of MSB
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- Reset (async assert, sync release): state IDLE. in_ready=1 after release. out_valid, sum, cout, ovf, zero, neg = 0. Chunk counter and carry register = 0.
- Arithmetic: result = a + (b XOR {WIDTH{sub}}) + (cin XOR sub), modulo 2^WIDTH.
  - sub=0, cin=0: a+b. sub=0, cin=1: a+b+1.
  - sub=1, cin=0: a-b. sub=1, cin=1: a-b-1 (borrow).
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register a, b XOR sub, and carry := cin XOR sub. Clear counter. Go to RUN.
  - RUN: in_ready=0. Each edge adds chunk[counter] of both operands plus the carry register. Write the CHUNK result bits into the sum shift/position register. Update the carry register. Increment counter. On the last chunk (counter==N-1), capture the carry into bit WIDTH-1 and the carry out of bit WIDTH-1, then go to DONE.
  - DONE: out_valid=1. sum, cout, ovf, zero and neg are registered and stable. On out_ready, go to IDLE; out_valid drops on that edge.
- Latency: out_valid is high exactly N edges after the accepting edge (N=4 at defaults, N=1 when CHUNK=WIDTH).
- Throughput: one operation per N+2 cycles minimum. No overlap; in_ready=0 in RUN and DONE.
- Inputs a, b, cin and sub are sampled only on the accepting edge. Later changes are ignored.
- in_valid while busy is ignored; no queueing.
- out_ready outside DONE is ignored.
- Backpressure: DONE is held indefinitely until out_ready; all outputs are held.
- zero and neg are computed from the final sum driven on the port, after saturation if enabled.
- Reset mid-RUN or mid-DONE aborts the operation immediately: all outputs go to their reset values and the result is discarded.

Optional Feature:
U2_ADDSUB_SAT_EN
- Defined: when ovf=1, sum saturates. If the sum MSB is 0 (negative overflow), sum = 1 followed by zeros (most negative value, 0x80 for WIDTH=8). If the sum MSB is 1 (positive overflow), sum = 0 followed by ones (most positive value, 0x7F for WIDTH=8). ovf and cout still report the raw condition. The substitution is applied on the RUN->DONE edge; latency is unchanged.
- Undefined: sum is the wrapped modulo-2^WIDTH result.

Test Plan:
- Defaults (W=8, C=2). add a=0x64, b=0x1B, cin=0 -> sum 0x7F, cout 0, ovf 0, neg 0, zero 0. out_valid 4 edges after accept.
- add a=0x64, b=0x1C -> ovf 1, cout 0. Without SAT_EN: sum 0x80, neg 1. With SAT_EN: sum 0x7F, neg 0.
- sub a=0x80, b=0x01, cin=0 -> ovf 1, cout 1. Without SAT_EN: sum 0x7F. With SAT_EN: sum 0x80. Then sub a=0x05, b=0x05, cin=1 -> sum 0xFF, neg 1, ovf 0.
- add a=0xFF, b=0x01, cin=0 -> sum 0x00, cout 1, ovf 0, zero 1.
- Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands -> out_valid and outputs stable, in_ready 0, new operands ignored. out_ready=1 -> out_valid 0 and in_ready 1 on the next cycle.
- Assert rst_n=0 asynchronously at RUN counter=2 -> all outputs 0 immediately, in_ready 1 after release. Next op 0x10+0x20 -> 0x30. Repeat with CHUNK=8 -> out_valid 1 edge after accept.

Source files
------------

// File: rtl/u2_addsub_seq.sv
// Multi-cycle U2 adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Optional saturation on signed overflow: define U2_ADDSUB_SAT_EN.
module u2_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("u2_addsub_seq: WIDTH must be >=2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  acc;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [CHUNK:0]    part;
    logic [WIDTH-1:0]  full;
    logic [WIDTH-1:0]  fin;
    logic              c_msb;
    logic              ovf_n;
    logic              last;
    int                idx;

    always_comb begin
        idx  = int'(cnt) * CHUNK;
        part = {1'b0, a_r[idx +: CHUNK]}
             + {1'b0, b_r[idx +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
        full = acc;
        full[idx +: CHUNK] = part[CHUNK-1:0];
        // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly
        c_msb = full[WIDTH-1] ^ a_r[WIDTH-1] ^ b_r[WIDTH-1];
        ovf_n = c_msb ^ part[CHUNK];
        fin   = full;
`ifdef U2_ADDSUB_SAT_EN
        if (ovf_n) begin
            fin = full[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
        last = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b ^ {WIDTH{sub}};
                        carry    <= cin ^ sub;
                        cnt      <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= full;
                    carry <= part[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum       <= fin;
                        cout      <= part[CHUNK];
                        ovf       <= ovf_n;
                        zero      <= (fin == '0);
                        neg       <= fin[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
